// File: rtl/csub64_pipe_pkg.sv
// Shared constants and stage payload type for the pipelined 64-bit carry-skip subtractor.
package csub64_pipe_pkg;

    localparam int unsigned WIDTH  = 64;
    localparam int unsigned SLICE  = 16;
    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned GROUP  = 4;

    // ad: resolved diff bits below the current slice, untouched minuend bits above it.
    // bs: subtrahend slices not yet consumed (consumed slices are cleared).
    typedef struct packed {
        logic             valid;
        logic             carry;
        logic             sa;
        logic             sb;
        logic [WIDTH-1:0] ad;
        logic [WIDTH-1:0] bs;
    } pipe_t;

    function automatic logic signed_ovf(input logic sa, input logic sb, input logic dmsb);
        return (sa != sb) && (dmsb != sa);
    endfunction

endpackage

// File: rtl/csub_skip_slice16.sv
// Combinational 16-bit a + ~b + cin slice built from 4-bit ripple groups with skip muxes.
module csub_skip_slice16
    import csub64_pipe_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] d,
    output logic        cout
);

    localparam int unsigned NGROUP = SLICE / GROUP;

    logic [15:0]       p;
    logic [15:0]       g;
    logic [NGROUP:0]   gc;
    logic              rc;

    assign p = a ^ ~b;
    assign g = a & ~b;

    always_comb begin
        d     = '0;
        gc    = '0;
        rc    = 1'b0;
        gc[0] = cin;
        for (int j = 0; j < int'(NGROUP); j++) begin
            rc = gc[j];
            for (int i = 0; i < int'(GROUP); i++) begin
                d[j*GROUP+i] = p[j*GROUP+i] ^ rc;
                rc           = g[j*GROUP+i] | (p[j*GROUP+i] & rc);
            end
            // A fully propagating group passes its carry-in straight through.
            gc[j+1] = (&p[j*GROUP +: GROUP]) ? gc[j] : rc;
        end
        cout = gc[NGROUP];
    end

endmodule

// File: rtl/csub64_pipe.sv
// Four-stage pipelined 64-bit subtractor (a - b) with valid/ready handshakes and result flags.
module csub64_pipe
    import csub64_pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] diff,
    output logic        bout,
    output logic        ovf,
    output logic        zero
);

    pipe_t st_q [NSLICE];
    pipe_t st_d [NSLICE];
    logic  en;

    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    for (genvar k = 0; k < NSLICE; k++) begin : g_stage
        pipe_t            cur;
        pipe_t            nxt;
        logic [SLICE-1:0] d;
        logic             cout;

        if (k == 0) begin : g_head
            assign cur = '{valid: in_valid, carry: 1'b1, sa: a[WIDTH-1], sb: b[WIDTH-1],
                           ad: a, bs: b};
        end else begin : g_body
            assign cur = st_q[k-1];
        end

        csub_skip_slice16 u_slice (
            .a    (cur.ad[k*SLICE +: SLICE]),
            .b    (cur.bs[k*SLICE +: SLICE]),
            .cin  (cur.carry),
            .d    (d),
            .cout (cout)
        );

        always_comb begin
            nxt                      = cur;
            nxt.carry                = cout;
            nxt.ad[k*SLICE +: SLICE] = d;
            nxt.bs[k*SLICE +: SLICE] = '0;
        end

        assign st_d[k] = nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(NSLICE); k++) begin
                st_q[k] <= '0;
            end
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < int'(NSLICE); k++) begin
                st_q[k] <= st_d[k];
            end
            out_valid <= st_q[NSLICE-1].valid;
            diff      <= st_q[NSLICE-1].ad;
            bout      <= ~st_q[NSLICE-1].carry;
            ovf       <= signed_ovf(st_q[NSLICE-1].sa, st_q[NSLICE-1].sb,
                                    st_q[NSLICE-1].ad[WIDTH-1]);
            zero      <= (st_q[NSLICE-1].ad == '0);
        end
    end

    // Every subtrahend slice has been consumed by the last stage.
    logic unused_bs;
    assign unused_bs = ^st_q[NSLICE-1].bs;

endmodule

// File: tb/tb_csub64_pipe.sv
// Bench for csub64_pipe: directed vector table, back-to-back stream, stall and mid-flight reset.
module tb_csub64_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;

    int checks   = 0;
    int failures = 0;
    int popped   = 0;

    typedef struct packed {
        logic [63:0] diff;
        logic        bout;
        logic        ovf;
        logic        zero;
    } res_t;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        res_t        exp;
    } vec_t;

    res_t exp_q[$];

    csub64_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic [63:0] x, input logic [63:0] y);
        res_t r;
        r.diff = x - y;
        r.bout = (x < y);
        r.ovf  = (x[63] != y[63]) && (r.diff[63] != x[63]);
        r.zero = (r.diff == 64'd0);
        return r;
    endfunction

    function automatic vec_t mkvec(input logic [63:0] x, input logic [63:0] y,
                                   input logic [63:0] d, input logic bo, input logic ov,
                                   input logic z);
        vec_t v;
        v.a        = x;
        v.b        = y;
        v.exp.diff = d;
        v.exp.bout = bo;
        v.exp.ovf  = ov;
        v.exp.zero = z;
        return v;
    endfunction

    // Single operation into an idle pipe; checks 4-cycle latency and a single result.
    task automatic run_vec(input string name, input vec_t v);
        int lat;
        @(negedge clk);
        in_valid  = 1'b1;
        a         = v.a;
        b         = v.b;
        out_ready = 1'b1;
        #1;
        chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, 64'(lat), 64'd4);
        chk({name, "_diff"}, diff, v.exp.diff);
        chk({name, "_flags"}, 64'({bout, ovf, zero}), 64'({v.exp.bout, v.exp.ovf, v.exp.zero}));
        @(negedge clk);
        chk({name, "_single"}, 64'(out_valid), 64'd0);
    endtask

    // One cycle of streaming traffic with scoreboard bookkeeping.
    task automatic step(input logic iv, input logic [63:0] ia, input logic [63:0] ib,
                        input logic ordy, output logic accepted);
        res_t e;
        @(negedge clk);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                popped++;
                chk("stream_diff", diff, e.diff);
                chk("stream_flags", 64'({bout, ovf, zero}), 64'({e.bout, e.ovf, e.zero}));
            end
        end
        if (out_valid && !out_ready) begin
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            if (exp_q.size() == 0) chk("stall_no_expected", 64'd1, 64'd0);
            else chk("stall_hold_diff", diff, exp_q[0].diff);
        end
        accepted = iv && in_ready;
        if (accepted) exp_q.push_back(model(ia, ib));
    endtask

    vec_t        vecs[9];
    logic        acc;
    logic [63:0] ra[8];
    logic [63:0] rb[8];
    int          idx;
    int          p0;

    initial begin
        vecs[0] = mkvec(64'd5, 64'd3, 64'd2, 1'b0, 1'b0, 1'b0);
        vecs[1] = mkvec(64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        vecs[2] = mkvec(64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0);
        vecs[3] = mkvec(64'h1234, 64'h1234, 64'd0, 1'b0, 1'b0, 1'b1);
        vecs[4] = mkvec(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                        64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0);
        vecs[5] = mkvec(64'h0001_0000_0000_0000, 64'd1, 64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
        vecs[6] = mkvec(64'h0000_0000_0001_0000, 64'd1, 64'h0000_0000_0000_FFFF, 1'b0, 1'b0, 1'b0);
        vecs[7] = mkvec(64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
        vecs[8] = mkvec(64'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b1, 1'b1, 1'b0);

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_diff", diff, 64'd0);
        chk("reset_flags", 64'({bout, ovf, zero}), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Back-to-back stream, consumer always ready.
        p0 = popped;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b1, acc);
            chk("stream_accept", 64'(acc), 64'd1);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 64'd0, 64'd0, 1'b1, acc);
        chk("stream_count", 64'(popped - p0), 64'd10);
        chk("stream_drained", 64'(exp_q.size()), 64'd0);

        // Consumer stalls for 6 cycles with the pipe full.
        for (int i = 0; i < 8; i++) begin
            ra[i] = {$urandom(), $urandom()};
            rb[i] = {$urandom(), $urandom()};
        end
        p0  = popped;
        idx = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            step(idx < 8, ra[idx % 8], rb[idx % 8], !(cyc >= 6 && cyc < 12), acc);
            if (cyc >= 6 && cyc < 12) chk("stall_out_valid", 64'(out_valid), 64'd1);
            if (acc) idx++;
        end
        chk("stall_count", 64'(popped - p0), 64'd8);
        chk("stall_drained", 64'(exp_q.size()), 64'd0);

        // Reset with operations in flight.
        for (int i = 0; i < 4; i++)
            step(1'b1, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b1, acc);
        step(1'b0, 64'd0, 64'd0, 1'b1, acc);
        step(1'b0, 64'd0, 64'd0, 1'b1, acc);
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", 64'(out_valid), 64'd0);
        chk("async_reset_diff", diff, 64'd0);
        chk("async_reset_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 64'd0, 64'd0, 1'b1, acc);
            chk("post_reset_no_stale", 64'(out_valid), 64'd0);
        end
        run_vec("after_reset", mkvec(64'd7, 64'd9, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
